note_player_env: RTL and testbench
==================================

Name: note_player_env

Overview:
- Next-generation note player for the music pipeline. It takes over from the fixed single-note player with the same song-reader-facing handshake.
- Adds four things:
  - latched note/duration loading;
  - parametrised duration width;
  - a linear attack/release amplitude envelope applied per beat;
  - rest (silent) notes.
- Sits between the song reader (note/duration/load/done) and the codec sample path (generate_next_sample / new_sample_ready).

Parameters:
- DUR_W, 6, width of duration_to_load and the internal beat counter.
- GAIN_W, 8, fractional bits of envelope gain; full scale = 2^GAIN_W.
- ATTACK_STEP, 64, gain increment per beat during attack (saturates at full scale).
- RELEASE_STEP, 64, gain decrement per beat during release (saturates at 0).
- RELEASE_BEATS, 4, number of final beats of a note spent in release.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  high = run; low = freeze beat counting, envelope and sample requests
- note_to_load  in  6  note index; 0 = rest
- duration_to_load  in  DUR_W  note length in beats
- load_new_note  in  1  one-cycle pulse; latches note and duration
- done_with_note  out  1  level high while idle/done
- beat  in  1  1/48 s strobe, one cycle wide
- generate_next_sample  in  1  codec sample request pulse
- sample_out  out  16  signed enveloped sample, registered
- new_sample_ready  out  1  one-cycle pulse, sample_out valid

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE, gain=0, count=0, note/duration regs=0;
  - sample_out=0, new_sample_ready=0, done_with_note=1.
- States: IDLE, LOAD, PLAY, RELEASE, DONE. done_with_note=1 in IDLE and DONE only.
- load_new_note in any state: latch note/duration, count=0, gain=0, go to LOAD. A load arriving mid-note aborts that note.
- LOAD lasts exactly 1 cycle (frequency_rom registered latency), then:
  - if duration=0, go to DONE;
  - if duration<=RELEASE_BEATS, go to RELEASE;
  - otherwise go to PLAY.
- PLAY: on beat && play_enable:
  - count++ and gain=min(gain+ATTACK_STEP, 2^GAIN_W);
  - when count+1 == duration-RELEASE_BEATS, go to RELEASE.
- RELEASE: on beat && play_enable:
  - count++ and gain=max(gain-RELEASE_STEP, 0);
  - when count+1 == duration, go to DONE.
- Total note length is therefore always exactly duration beats after LOAD, regardless of envelope.
- DONE: hold; gain forced to 0. Leave only on load.
- beat and load_new_note in the same cycle: load wins and the beat is ignored.
- Sample path:
  - sine_reader.generate_next = play_enable && generate_next_sample && state in {PLAY, RELEASE}.
  - One cycle after sine_reader sample_ready:
    - sample_out = (sine_sample * gain) >>> GAIN_W, as a signed product of width 16+GAIN_W+2;
    - new_sample_ready pulses.
  - Gain is sampled in the same cycle as sample_ready.
- Rest (note 0): state machine and timing are identical, but sample_out=0 on every ready pulse.
- In IDLE/DONE/LOAD, no sample requests are forwarded and new_sample_ready stays 0.
- Gain register width is GAIN_W+1. Full-scale gain passes the sine through exactly; no overflow is possible.
- play_enable low: no state, count or gain change, no sample requests. A load is still accepted.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE) and NOTE_REST=0.
- Reuse existing frequency_rom (6-bit addr to 20-bit step, 1-cycle latency) and sine_reader unchanged.
- One new natural sub-module, env_gain: a saturating up/down gain register with inc/dec/clear controls.

Test Plan:
- Reset then load note 20, duration 10 (defaults):
  - done drops the cycle after load;
  - gain after beats 1..4 = 64, 128, 192, 256;
  - RELEASE entered after beat 6;
  - gain after beats 7..10 = 192, 128, 64, 0;
  - done rises with beat 10.
- Duration 3 (<= RELEASE_BEATS): LOAD goes straight to RELEASE, gain stays 0, done after 3 beats. Duration 0: done high 2 cycles after load, no samples.
- Note 0, duration 5, with generate_next_sample pulses: new_sample_ready pulses with sample_out=0; done after 5 beats.
- Sample path at full gain:
  - sine_reader returns 0x4000 (+16384) -> sample_out=0x4000;
  - at gain 128, sample -16384 -> sample_out=-8192.
- Clock-level checks:
  - play_enable low for 20 beats mid-PLAY: count, gain and state frozen, no new_sample_ready.
  - beat and load_new_note in the same cycle: count=0 and gain=0 afterwards.
- Reset pulsed low mid-RELEASE:
  - all outputs take reset values immediately (asynchronous);
  - block resumes in IDLE with done_with_note=1 after release.

Source files
------------

// File: rtl/note_player_env_pkg.sv
// rtl/note_player_env_pkg.sv - shared state encoding and constants for the enveloped note player
package note_player_env_pkg;

    localparam int NOTE_W   = 6;
    localparam int STEP_W   = 20;
    localparam int SAMPLE_W = 16;

    // Note index 0 is a rest: full timing, silent output.
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PLAY    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // States in which the player produces audio and beats advance the note.
    function automatic logic is_sounding(input state_t s);
        return (s == ST_PLAY) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/note_player_env_if.sv
// rtl/note_player_env_if.sv - song reader and codec sample handshake bundle
// master: song reader / codec side; slave: note player.
interface note_player_env_if #(
    parameter int DUR_W = 6
);
    import note_player_env_pkg::*;

    logic [NOTE_W-1:0]          note_to_load;
    logic [DUR_W-1:0]           duration_to_load;
    logic                       load_new_note;
    logic                       done_with_note;
    logic                       generate_next_sample;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       new_sample_ready;

    modport master (
        output note_to_load,
        output duration_to_load,
        output load_new_note,
        output generate_next_sample,
        input  done_with_note,
        input  sample_out,
        input  new_sample_ready
    );

    modport slave (
        input  note_to_load,
        input  duration_to_load,
        input  load_new_note,
        input  generate_next_sample,
        output done_with_note,
        output sample_out,
        output new_sample_ready
    );

endinterface

// File: rtl/frequency_rom.sv
// rtl/frequency_rom.sv - note index to phase step lookup, one cycle latency
// addr: note index; dout: registered phase step for sine_reader.
module frequency_rom
    import note_player_env_pkg::*;
(
    input  logic              clk,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= STEP_W'(addr) * STEP_W'(2111);
    end

endmodule

// File: rtl/note_player_env_gain.sv
// rtl/note_player_env_gain.sv - saturating up/down envelope gain register
// inc: add ATTACK_STEP up to full scale; dec: subtract RELEASE_STEP down to 0;
// clear: force 0 (highest priority); gain: unsigned, full scale = 2^GAIN_W.
module env_gain #(
    parameter int GAIN_W       = 8,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            inc,
    input  logic            dec,
    output logic [GAIN_W:0] gain
);

    localparam logic [GAIN_W:0] FULL_G = (GAIN_W+1)'(1 << GAIN_W);
    localparam logic [GAIN_W:0] ATT_G  = (GAIN_W+1)'(ATTACK_STEP);
    localparam logic [GAIN_W:0] REL_G  = (GAIN_W+1)'(RELEASE_STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gain <= '0;
        end else if (clear) begin
            gain <= '0;
        end else if (inc) begin
            // Compare before adding so the sum never exceeds GAIN_W+1 bits.
            gain <= (gain >= FULL_G - ATT_G) ? FULL_G : gain + ATT_G;
        end else if (dec) begin
            gain <= (gain <= REL_G) ? '0 : gain - REL_G;
        end
    end

endmodule

// File: rtl/sine_reader.sv
// rtl/sine_reader.sv - phase accumulator sine source, one sample per request
// step_size: phase increment; generate_next: request pulse;
// sample_ready: pulse one cycle after a request; sample: signed sine value.
module sine_reader
    import note_player_env_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [STEP_W-1:0]          step_size,
    input  logic                       generate_next,
    output logic                       sample_ready,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [STEP_W-1:0] phase;

    // Sixteen points of one period at amplitude 16384.
    function automatic logic signed [SAMPLE_W-1:0] sine_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    sine_lut = 16'sd0;
            4'd1:    sine_lut = 16'sd6270;
            4'd2:    sine_lut = 16'sd11585;
            4'd3:    sine_lut = 16'sd15137;
            4'd4:    sine_lut = 16'sd16384;
            4'd5:    sine_lut = 16'sd15137;
            4'd6:    sine_lut = 16'sd11585;
            4'd7:    sine_lut = 16'sd6270;
            4'd8:    sine_lut = 16'sd0;
            4'd9:    sine_lut = -16'sd6270;
            4'd10:   sine_lut = -16'sd11585;
            4'd11:   sine_lut = -16'sd15137;
            4'd12:   sine_lut = -16'sd16384;
            4'd13:   sine_lut = -16'sd15137;
            4'd14:   sine_lut = -16'sd11585;
            default: sine_lut = -16'sd6270;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase        <= '0;
            sample       <= '0;
            sample_ready <= 1'b0;
        end else begin
            sample_ready <= generate_next;
            if (generate_next) begin
                sample <= sine_lut(phase[STEP_W-1 -: 4]);
                phase  <= phase + step_size;
            end
        end
    end

endmodule

// File: rtl/note_player_env.sv
// rtl/note_player_env.sv - note player with latched loads, rests and linear attack/release envelope
// clk, reset (async, active low); play_enable: run/freeze; beat: beat strobe;
// io: note/duration/load/done toward the song reader, generate_next_sample /
//     sample_out / new_sample_ready toward the codec.
module note_player_env
    import note_player_env_pkg::*;
#(
    parameter int DUR_W         = 6,
    parameter int GAIN_W        = 8,
    parameter int ATTACK_STEP   = 64,
    parameter int RELEASE_STEP  = 64,
    parameter int RELEASE_BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic play_enable,
    input  logic beat,
    note_player_env_if.slave io
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 2;
    localparam logic [DUR_W-1:0] REL_BEATS_D = DUR_W'(RELEASE_BEATS);

    state_t                     state;
    state_t                     state_next;
    logic [DUR_W-1:0]           count;
    logic [DUR_W-1:0]           count_next;
    logic [DUR_W-1:0]           count_inc;
    logic [DUR_W-1:0]           dur_reg;
    logic [NOTE_W-1:0]          note_reg;
    logic                       tick;
    logic                       gain_inc;
    logic                       gain_dec;
    logic                       gain_clear;
    logic [GAIN_W:0]            gain;
    logic [STEP_W-1:0]          step;
    logic                       sine_gen;
    logic                       sine_ready;
    logic signed [SAMPLE_W-1:0] sine_sample;
    logic signed [PROD_W-1:0]   product;
    logic signed [SAMPLE_W-1:0] scaled;
    logic signed [SAMPLE_W-1:0] sample_out_r;
    logic                       new_sample_ready_r;

    assign tick      = beat && play_enable;
    assign count_inc = count + DUR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            note_reg <= '0;
            dur_reg  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (io.load_new_note) begin
                note_reg <= io.note_to_load;
                dur_reg  <= io.duration_to_load;
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        gain_inc   = 1'b0;
        gain_dec   = 1'b0;
        gain_clear = 1'b0;
        // A load overrides everything, including a beat in the same cycle.
        if (io.load_new_note) begin
            state_next = ST_LOAD;
            count_next = '0;
            gain_clear = 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    // One cycle here covers the frequency_rom read latency.
                    if (dur_reg == '0) begin
                        state_next = ST_DONE;
                    end else if (dur_reg <= REL_BEATS_D) begin
                        state_next = ST_RELEASE;
                    end else begin
                        state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        count_next = count_inc;
                        gain_inc   = 1'b1;
                        if (count_inc == dur_reg - REL_BEATS_D) begin
                            state_next = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tick) begin
                        count_next = count_inc;
                        gain_dec   = 1'b1;
                        if (count_inc == dur_reg) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    gain_clear = 1'b1;
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    env_gain #(
        .GAIN_W       (GAIN_W),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_gain (
        .clk   (clk),
        .reset (reset),
        .clear (gain_clear),
        .inc   (gain_inc),
        .dec   (gain_dec),
        .gain  (gain)
    );

    frequency_rom u_rom (
        .clk  (clk),
        .addr (note_reg),
        .dout (step)
    );

    assign sine_gen = play_enable && io.generate_next_sample && is_sounding(state);

    sine_reader u_sine (
        .clk           (clk),
        .reset         (reset),
        .step_size     (step),
        .generate_next (sine_gen),
        .sample_ready  (sine_ready),
        .sample        (sine_sample)
    );

    // Gain is unsigned, so a zero sign bit is prepended before the signed
    // multiply; full-scale gain then reproduces the sine exactly.
    assign product = PROD_W'(sine_sample) * PROD_W'($signed({1'b0, gain}));
    assign scaled  = SAMPLE_W'(product >>> GAIN_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out_r       <= '0;
            new_sample_ready_r <= 1'b0;
        end else begin
            new_sample_ready_r <= sine_ready && is_sounding(state);
            if (sine_ready && is_sounding(state)) begin
                sample_out_r <= (note_reg == NOTE_REST) ? '0 : scaled;
            end
        end
    end

    assign io.sample_out       = sample_out_r;
    assign io.new_sample_ready = new_sample_ready_r;
    assign io.done_with_note   = (state == ST_IDLE) || (state == ST_DONE);

endmodule

// File: tb/tb_note_player_env.sv
// tb/tb_note_player_env.sv - scoreboard bench for note_player_env
module tb_note_player_env;
    import note_player_env_pkg::*;

    localparam int RB   = 4;
    localparam int ATT  = 64;
    localparam int REL  = 64;
    localparam int FULL = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic play_enable = 1'b1;
    logic beat = 1'b0;

    note_player_env_if io ();

    note_player_env dut (
        .clk         (clk),
        .reset       (reset),
        .play_enable (play_enable),
        .beat        (beat),
        .io          (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef enum {M_IDLE, M_LOAD, M_ACTIVE, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int m_note = 0;
    int m_dur = 0;
    int m_beats = 0;
    int m_gain = 0;

    typedef struct {
        int gain;
        bit rest;
    } rec_t;
    rec_t exp_q[$];
    rec_t r;
    int cap_sine = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Envelope after k beats of a note of length d: linear ramp for the
    // first d-RB beats (clipped at full scale), then linear fall to 0.
    function automatic int env_after(input int d, input int k);
        int a;
        int peak;
        int v;
        a = (d > RB) ? d - RB : 0;
        if (k <= a) return (k * ATT > FULL) ? FULL : k * ATT;
        peak = (a * ATT > FULL) ? FULL : a * ATT;
        v = peak - (k - a) * REL;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int scale(input int s, input int g);
        int p;
        int q;
        p = s * g;
        q = p / FULL;
        if (p < 0 && q * FULL != p) q = q - 1;
        return q;
    endfunction

    function automatic state_t model_state();
        case (m_mode)
            M_IDLE:  return ST_IDLE;
            M_LOAD:  return ST_LOAD;
            M_DONE:  return ST_DONE;
            default: return (m_beats < m_dur - RB) ? ST_PLAY : ST_RELEASE;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_note = 0;
        m_dur = 0;
        m_beats = 0;
        m_gain = 0;
    endfunction

    function automatic void model_step(input bit ld, input int n, input int d, input bit bt, input bit pe);
        if (ld) begin
            m_note = n;
            m_dur = d;
            m_beats = 0;
            m_gain = 0;
            m_mode = M_LOAD;
        end else if (m_mode == M_LOAD) begin
            m_mode = (m_dur == 0) ? M_DONE : M_ACTIVE;
        end else if (m_mode == M_ACTIVE && bt && pe) begin
            m_beats++;
            m_gain = env_after(m_dur, m_beats);
            if (m_beats == m_dur) begin
                m_mode = M_DONE;
                m_gain = 0;
            end
        end
    endfunction

    // One clock: drive at the falling edge, let the model follow the rising
    // edge, and return at the next falling edge.
    task automatic cycle(input bit ld, input int n, input int d, input bit bt, input bit g);
        bit pe;
        io.load_new_note = ld;
        io.note_to_load = 6'(n);
        io.duration_to_load = 6'(d);
        beat = bt;
        io.generate_next_sample = g;
        pe = play_enable;
        if (g && pe && m_mode == M_ACTIVE) exp_q.push_back('{m_gain, m_note == 0});
        @(posedge clk);
        #1;
        if (reset) model_step(ld, n, d, bt, pe);
        io.load_new_note = 1'b0;
        beat = 1'b0;
        io.generate_next_sample = 1'b0;
        @(negedge clk);
    endtask

    // Remainder of an 8-cycle beat period; sample requests only in slots 2..5
    // so no beat or load lands while a request is in flight.
    task automatic fill(input int pct);
        for (int s = 1; s < 8; s++) begin
            cycle(0, 0, 0, 0, (s >= 2 && s <= 5) && ($urandom_range(0, 99) < pct));
        end
    endtask

    always @(negedge clk) begin
        check("done_with_note", io.done_with_note, (m_mode == M_IDLE || m_mode == M_DONE) ? 1 : 0);
        check("state", dut.state, model_state());
        check("count", dut.count, m_beats);
        check("gain", dut.gain, m_gain);
        if (io.new_sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_sample: actual pulse value %0d required no pulse", $signed(io.sample_out));
            end else begin
                r = exp_q.pop_front();
                check("sample_out", $signed(io.sample_out), r.rest ? 0 : scale(cap_sine, r.gain));
            end
        end
        if (dut.sine_ready) cap_sine = $signed(dut.sine_sample);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    int gain_tab[10] = '{64, 128, 192, 256, 256, 256, 192, 128, 64, 0};

    initial begin
        io.load_new_note = 1'b0;
        io.note_to_load = '0;
        io.duration_to_load = '0;
        io.generate_next_sample = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_done", io.done_with_note, 1);
        check("reset_sample_out", io.sample_out, 0);
        check("reset_ready", io.new_sample_ready, 0);
        reset = 1'b1;
        @(negedge clk);

        // Default note: 20 for 10 beats.
        cycle(1, 20, 10, 0, 0);
        check("done_drop", io.done_with_note, 0);
        fill(0);
        for (int b = 0; b < 10; b++) begin
            cycle(0, 0, 0, 1, 0);
            check("gain_curve", dut.gain, gain_tab[b]);
            if (b == 5) check("release_after_6", dut.state, ST_RELEASE);
            check("done_at_beat", io.done_with_note, (b == 9) ? 1 : 0);
            fill(60);
        end

        // Short note goes straight to release.
        cycle(1, 20, 3, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("short_to_release", dut.state, ST_RELEASE);
        fill(50);
        for (int b = 0; b < 3; b++) begin
            cycle(0, 0, 0, 1, 0);
            fill(50);
        end
        check("short_done", io.done_with_note, 1);

        // Zero duration.
        cycle(1, 20, 0, 0, 0);
        check("zero_dur_load", io.done_with_note, 0);
        cycle(0, 0, 0, 0, 1);
        check("zero_dur_done", io.done_with_note, 1);
        fill(100);

        // Rest note.
        cycle(1, 0, 5, 0, 0);
        fill(100);
        for (int b = 0; b < 5; b++) begin
            cycle(0, 0, 0, 1, 0);
            fill(100);
        end
        check("rest_done", io.done_with_note, 1);

        // Freeze with play_enable low mid-play.
        cycle(1, 20, 20, 0, 0);
        fill(0);
        for (int b = 0; b < 3; b++) begin
            cycle(0, 0, 0, 1, 0);
            fill(50);
        end
        play_enable = 1'b0;
        for (int b = 0; b < 20; b++) begin
            cycle(0, 0, 0, 1, 0);
            fill(100);
        end
        check("freeze_count", dut.count, 3);
        check("freeze_gain", dut.gain, 192);
        play_enable = 1'b1;

        // Beat and load together: load wins.
        cycle(1, 33, 8, 1, 0);
        check("load_beat_count", dut.count, 0);
        check("load_beat_gain", dut.gain, 0);
        fill(0);

        // Asynchronous reset in release.
        cycle(1, 20, 10, 0, 0);
        fill(0);
        for (int b = 0; b < 7; b++) begin
            cycle(0, 0, 0, 1, 0);
            fill(100);
        end
        @(posedge clk);
        #1;
        model_step(0, 0, 0, 0, play_enable);
        #2;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check("async_sample_out", io.sample_out, 0);
        check("async_ready", io.new_sample_ready, 0);
        check("async_done", io.done_with_note, 1);
        @(negedge clk);
        cycle(0, 0, 0, 1, 0);
        reset = 1'b1;
        cycle(0, 0, 0, 1, 0);
        check("post_reset_idle", dut.state, ST_IDLE);
        check("post_reset_done", io.done_with_note, 1);

        // Randomized notes, aborts, rests and freezes.
        for (int p = 0; p < 400; p++) begin
            bit ld;
            int n;
            int d;
            play_enable = ($urandom_range(0, 9) != 0);
            ld = (m_mode == M_DONE || m_mode == M_IDLE) ? 1'b1 : ($urandom_range(0, 29) == 0);
            n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
            d = $urandom_range(0, 14);
            cycle(ld, n, d, $urandom_range(0, 4) != 0, 0);
            fill($urandom_range(0, 100));
        end
        play_enable = 1'b1;
        fill(0);

        check("sample_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
